// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the 7-segment scan-bus decoder.
package seg_scan_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned AN_W    = 4;
    localparam int unsigned DIG_W   = 4;
    localparam int unsigned SLOT_W  = 2;
    localparam int unsigned HRS_W   = 5;
    localparam int unsigned MINS_W  = 6;
    localparam int unsigned ARITH_W = 7;

    // Active-high a..g patterns, bit0 = a.
    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;

    localparam logic [AN_W-1:0] AN_MIN_LO = 4'b1110;
    localparam logic [AN_W-1:0] AN_MIN_HI = 4'b1101;
    localparam logic [AN_W-1:0] AN_HR_LO  = 4'b1011;
    localparam logic [AN_W-1:0] AN_HR_HI  = 4'b0111;

    typedef enum logic [1:0] {SYNC, CAP, CHECK} state_t;

    typedef struct packed {
        logic              ok;
        logic [SLOT_W-1:0] slot;
    } slot_t;

    typedef struct packed {
        logic              vld;
        logic              an_ok;
        logic              dig_ok;
        logic [SLOT_W-1:0] slot;
        logic [DIG_W-1:0]  digit;
    } sample_t;

    // Anode code to slot index; ok only when exactly one enable is low.
    function automatic slot_t an_decode(input logic [AN_W-1:0] an);
        slot_t r;
        r = '0;
        case (an)
            AN_MIN_LO: r = '{ok: 1'b1, slot: 2'd0};
            AN_MIN_HI: r = '{ok: 1'b1, slot: 2'd1};
            AN_HR_LO:  r = '{ok: 1'b1, slot: 2'd2};
            AN_HR_HI:  r = '{ok: 1'b1, slot: 2'd3};
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Active-high 7-segment pattern to BCD digit, with a flag for unknown patterns.
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic [DIG_W-1:0] digit_c,
    output logic             valid_c
);

    always_comb begin
        digit_c = '0;
        valid_c = 1'b1;
        case (pattern)
            SEG_0:   digit_c = 4'd0;
            SEG_1:   digit_c = 4'd1;
            SEG_2:   digit_c = 4'd2;
            SEG_3:   digit_c = 4'd3;
            SEG_4:   digit_c = 4'd4;
            SEG_5:   digit_c = 4'd5;
            SEG_6:   digit_c = 4'd6;
            SEG_7:   digit_c = 4'd7;
            SEG_8:   digit_c = 4'd8;
            SEG_9:   digit_c = 4'd9;
            default: valid_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers HH:MM from a multiplexed active-low 7-segment scan bus; publishes
// a time only after two identical in-range frames.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int unsigned SETTLE  = 16,
    parameter int unsigned TIMEOUT = 1_048_576,
    parameter int unsigned TW      = 21
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEG_W-1:0]  segments,
    input  logic [AN_W-1:0]   anodes,
    output logic [HRS_W-1:0]  hrs,
    output logic [MINS_W-1:0] mins,
    output logic              time_valid,
    output logic              time_stb,
    output logic              err_pattern,
    output logic              err_range,
    output logic              stall
);

    logic [AN_W-1:0]  an_q, an_prev;
    logic [SEG_W-1:0] seg_q;
    logic [TW-1:0]    cnt;
    logic             chg_c, sample_c, stall_hit_c;
    slot_t            an_dec_c;
    logic [DIG_W-1:0] dig_c;
    logic             dig_ok_c;
    sample_t          smp;

    state_t                  state, state_n;
    logic [SLOT_W-1:0]       exp_slot, exp_slot_n;
    logic [3:0][DIG_W-1:0]   frame, frame_n;
    logic                    cand_vld, cand_vld_n;
    logic [HRS_W-1:0]        cand_hrs, cand_hrs_n;
    logic [MINS_W-1:0]       cand_mins, cand_mins_n;
    logic [HRS_W-1:0]        hrs_n;
    logic [MINS_W-1:0]       mins_n;
    logic                    time_valid_n, time_stb_n, err_pattern_n, err_range_n;
    logic [ARITH_W-1:0]      mins7_c, hrs7_c;
    logic                    in_range_c, same_c, accept0_c;

    seg7_decode u_dec (
        .pattern (~seg_q),
        .digit_c (dig_c),
        .valid_c (dig_ok_c)
    );

    assign an_dec_c    = an_decode(an_q);
    assign chg_c       = (an_q != an_prev);
    // cnt = cycles the current code has been held, minus one
    assign sample_c    = !chg_c && (cnt == TW'(SETTLE - 1));
    assign stall_hit_c = !chg_c && (cnt == TW'(TIMEOUT));

    // Input synchronisation, settle/timeout counter and slot sampling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_q    <= '0;
            an_prev <= '0;
            seg_q   <= '0;
            cnt     <= '0;
            stall   <= 1'b0;
            smp     <= '0;
        end else begin
            an_q    <= anodes;
            an_prev <= an_q;
            seg_q   <= segments;
            if (chg_c)
                cnt <= TW'(1);
            else if (cnt != TW'(TIMEOUT))
                cnt <= cnt + TW'(1);
            if (chg_c && an_dec_c.ok)
                stall <= 1'b0;
            else if (stall_hit_c)
                stall <= 1'b1;
            smp <= '{vld: sample_c, an_ok: an_dec_c.ok, dig_ok: dig_ok_c,
                     slot: an_dec_c.slot, digit: dig_c};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SYNC;
        else        state <= state_n;
    end

    assign accept0_c = smp.vld && smp.an_ok && smp.dig_ok && (smp.slot == SLOT_W'(0));

    always_comb begin
        state_n = state;
        if (stall_hit_c) begin
            state_n = SYNC;
        end else begin
            case (state)
                SYNC:  if (accept0_c) state_n = CAP;
                CAP: begin
                    if (smp.vld) begin
                        if (!smp.an_ok || !smp.dig_ok || (smp.slot != exp_slot))
                            state_n = SYNC;
                        else if (smp.slot == SLOT_W'(3))
                            state_n = CHECK;
                    end
                end
                CHECK:   state_n = CAP;
                default: state_n = SYNC;
            endcase
        end
    end

    // Frame arithmetic in 7 bits; truncation happens only after the range check.
    assign mins7_c    = ARITH_W'(frame[1]) * ARITH_W'(10) + ARITH_W'(frame[0]);
    assign hrs7_c     = ARITH_W'(frame[3]) * ARITH_W'(10) + ARITH_W'(frame[2]);
    assign in_range_c = (frame[1] <= DIG_W'(5)) && (hrs7_c <= ARITH_W'(23));
    assign same_c     = cand_vld && (cand_hrs == HRS_W'(hrs7_c))
                        && (cand_mins == MINS_W'(mins7_c));

    always_comb begin
        exp_slot_n    = exp_slot;
        frame_n       = frame;
        cand_vld_n    = cand_vld;
        cand_hrs_n    = cand_hrs;
        cand_mins_n   = cand_mins;
        hrs_n         = hrs;
        mins_n        = mins;
        time_valid_n  = time_valid;
        time_stb_n    = 1'b0;
        err_pattern_n = 1'b0;
        err_range_n   = 1'b0;
        if (stall_hit_c) begin
            time_valid_n = 1'b0;
            cand_vld_n   = 1'b0;
            cand_hrs_n   = '0;
            cand_mins_n  = '0;
        end else begin
            case (state)
                SYNC: begin
                    if (accept0_c) begin
                        frame_n[0] = smp.digit;
                        exp_slot_n = SLOT_W'(1);
                    end
                end
                CAP: begin
                    if (smp.vld) begin
                        if (!smp.an_ok || !smp.dig_ok) begin
                            err_pattern_n = 1'b1;
                        end else if (smp.slot == exp_slot) begin
                            frame_n[smp.slot] = smp.digit;
                            exp_slot_n        = exp_slot + SLOT_W'(1);
                        end
                    end
                end
                CHECK: begin
                    exp_slot_n = SLOT_W'(0);
                    if (!in_range_c) begin
                        err_range_n = 1'b1;
                        cand_vld_n  = 1'b0;
                        cand_hrs_n  = '0;
                        cand_mins_n = '0;
                    end else if (same_c) begin
                        hrs_n        = HRS_W'(hrs7_c);
                        mins_n       = MINS_W'(mins7_c);
                        time_valid_n = 1'b1;
                        time_stb_n   = 1'b1;
                    end else begin
                        cand_vld_n  = 1'b1;
                        cand_hrs_n  = HRS_W'(hrs7_c);
                        cand_mins_n = MINS_W'(mins7_c);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_slot    <= '0;
            frame       <= '0;
            cand_vld    <= 1'b0;
            cand_hrs    <= '0;
            cand_mins   <= '0;
            hrs         <= '0;
            mins        <= '0;
            time_valid  <= 1'b0;
            time_stb    <= 1'b0;
            err_pattern <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            exp_slot    <= exp_slot_n;
            frame       <= frame_n;
            cand_vld    <= cand_vld_n;
            cand_hrs    <= cand_hrs_n;
            cand_mins   <= cand_mins_n;
            hrs         <= hrs_n;
            mins        <= mins_n;
            time_valid  <= time_valid_n;
            time_stb    <= time_stb_n;
            err_pattern <= err_pattern_n;
            err_range   <= err_range_n;
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: frames are driven, expected output
// events queued with their cycle, and matched as the DUT raises them.
module tb_seg_scan_decoder;

    localparam int unsigned SETTLE  = 16;
    localparam int unsigned TIMEOUT = 2000;
    localparam int unsigned TW      = 21;
    localparam int unsigned HOLD    = SETTLE + 100;

    localparam logic [2:0] K_STB = 3'b100;
    localparam logic [2:0] K_RNG = 3'b010;
    localparam logic [2:0] K_PAT = 3'b001;

    logic       clk, reset;
    logic [6:0] segments;
    logic [3:0] anodes;
    logic [4:0] hrs;
    logic [5:0] mins;
    logic       time_valid, time_stb, err_pattern, err_range, stall;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
        int         h;
        int         m;
        logic       v;
    } evt_t;

    evt_t sb[$];
    evt_t e_m;
    evt_t e_d;
    int   cyc    = 0;
    int   n_pass = 0;
    int   n_chk  = 0;

    int   mod_h = 0, mod_m = 0, cand_h = 0, cand_m = 0;
    logic mod_v = 1'b0, cand_ok = 1'b0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [3:0] an_tab  [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] bad_pat      = 7'h49;

    seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk         (clk),
        .reset       (reset),
        .segments    (segments),
        .anodes      (anodes),
        .hrs         (hrs),
        .mins        (mins),
        .time_valid  (time_valid),
        .time_stb    (time_stb),
        .err_pattern (err_pattern),
        .err_range   (err_range),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_hrs"}, 32'(hrs), 32'(mod_h));
        check({tag, "_mins"}, 32'(mins), 32'(mod_m));
        check({tag, "_valid"}, 32'(time_valid), 32'(mod_v));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, 32'({hrs, mins, time_valid, time_stb, err_pattern, err_range, stall}), 0);
    endtask

    // Confirmation model applied once a complete frame's last slot is driven.
    task automatic model_frame(input int hv, input int mv, input int c);
        if (mv / 10 > 5 || hv > 23) begin
            cand_ok = 1'b0;
            e_d = '{kind: K_RNG, cyc: c + SETTLE + 3, h: mod_h, m: mod_m, v: mod_v};
            sb.push_back(e_d);
        end else if (cand_ok && cand_h == hv && cand_m == mv) begin
            mod_h = hv; mod_m = mv; mod_v = 1'b1;
            e_d = '{kind: K_STB, cyc: c + SETTLE + 3, h: mod_h, m: mod_m, v: mod_v};
            sb.push_back(e_d);
        end else begin
            cand_ok = 1'b1; cand_h = hv; cand_m = mv;
        end
    endtask

    task automatic drive_frame(input int hv, input int mv, input int bad_slot, input bit glitch);
        int         dg [4];
        int         c;
        logic [6:0] pat;
        dg[0] = mv % 10; dg[1] = mv / 10; dg[2] = hv % 10; dg[3] = hv / 10;
        for (int s = 0; s < 4; s++) begin
            pat = seg_tab[dg[s]];
            if (s == bad_slot) pat = bad_pat;
            segments = ~pat;
            anodes   = an_tab[s];
            if (glitch && s == 1) begin
                hold(5);
                anodes = 4'b0111;
                hold(SETTLE - 1);
                anodes = an_tab[1];
            end
            c = cyc;
            if (s == bad_slot) begin
                e_d = '{kind: K_PAT, cyc: c + SETTLE + 2, h: mod_h, m: mod_m, v: mod_v};
                sb.push_back(e_d);
            end
            if (s == 3 && bad_slot < 0) model_frame(hv, mv, c);
            hold(HOLD);
        end
    endtask

    // Every pulse on an event output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && (time_stb || err_range || err_pattern)) begin
            if (sb.size() == 0) begin
                check("unexpected_event", 32'({time_stb, err_range, err_pattern}), 0);
            end else begin
                e_m = sb.pop_front();
                check("event_kind", 32'({time_stb, err_range, err_pattern}), 32'(e_m.kind));
                check("event_cycle", 32'(cyc), 32'(e_m.cyc));
                check("event_hrs", 32'(hrs), 32'(e_m.h));
                check("event_mins", 32'(mins), 32'(e_m.m));
                check("event_valid", 32'(time_valid), 32'(e_m.v));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        anodes   = 4'b1111;
        segments = 7'h7F;
        hold(3);
        check_all_zero("reset");
        reset = 1'b1;
        hold(5);
        check_all_zero("post_reset");

        drive_frame(12, 34, -1, 1'b0);
        drive_frame(12, 34, -1, 1'b0);
        check_outputs("confirm_1234");

        drive_frame(12, 35, -1, 1'b0);
        check_outputs("no_update_1235");
        drive_frame(12, 35, -1, 1'b0);
        check_outputs("confirm_1235");

        drive_frame(8, 15, 1, 1'b0);
        check_outputs("hold_after_bad_pattern");
        drive_frame(8, 15, -1, 1'b0);
        drive_frame(8, 15, -1, 1'b0);
        check_outputs("confirm_0815");

        drive_frame(25, 7, -1, 1'b0);
        drive_frame(25, 7, -1, 1'b0);
        check_outputs("hold_after_range");

        drive_frame(9, 59, -1, 1'b0);
        drive_frame(9, 59, -1, 1'b0);
        check_outputs("confirm_0959");

        anodes   = 4'b1110;
        segments = ~seg_tab[9];
        hold(TIMEOUT + 10);
        mod_v   = 1'b0;
        cand_ok = 1'b0;
        check("stall_set", 32'(stall), 1);
        check_outputs("stalled");

        anodes = 4'b1111;
        hold(4);
        drive_frame(10, 0, -1, 1'b0);
        check("stall_clear", 32'(stall), 0);
        drive_frame(10, 0, -1, 1'b0);
        check_outputs("confirm_1000");

        drive_frame(14, 22, -1, 1'b1);
        drive_frame(14, 22, -1, 1'b0);
        check_outputs("confirm_1422_glitch");

        anodes   = an_tab[0];
        segments = ~seg_tab[5];
        hold(HOLD);
        anodes   = an_tab[1];
        segments = ~seg_tab[4];
        hold(30);
        reset = 1'b0;
        #1;
        check_all_zero("mid_frame_reset");
        mod_h = 0; mod_m = 0; mod_v = 1'b0; cand_ok = 1'b0;
        hold(3);
        reset = 1'b1;
        hold(2);
        drive_frame(16, 45, -1, 1'b0);
        check_outputs("one_frame_after_reset");
        drive_frame(16, 45, -1, 1'b0);
        check_outputs("confirm_1645");

        hold(20);
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the clock's multiplexed 7-segment display drive.
- Watches the active-low segments/anodes scan bus, debounces each digit slot and decodes the segment patterns back to digits.
- Reassembles HH:MM and publishes it only after two identical, in-range frames.
- Used as an on-board self-check and as a time source for downstream logic.

Parameters:
- SETTLE, 16, cycles an anode code must be held stable before its segments are sampled.
- TIMEOUT, 1_048_576, cycles without a valid anode change before the scan is declared stalled (digit slot is 262_144 cycles).
- TW, 21, width of the settle/timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- segments  in  7  active-low segment lines, bit0=a … bit6=g
- anodes  in  4  active-low digit enables: 1110=min ones, 1101=min tens, 1011=hr ones, 0111=hr tens
- hrs  out  5  decoded hours, binary 0..23
- mins  out  6  decoded minutes, binary 0..59
- time_valid  out  1  hrs/mins hold a confirmed time
- time_stb  out  1  one-cycle pulse when hrs/mins update
- err_pattern  out  1  one-cycle pulse: an unknown segment pattern or an illegal anode code arrived mid-frame
- err_range  out  1  one-cycle pulse: a complete frame decoded out of range (min tens >5, hours >23)
- stall  out  1  level: no valid anode change for TIMEOUT cycles

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM in SYNC, frame buffers and candidate cleared, counter 0.
- Anode handling:
  - Register anodes and segments once for synchronisation.
  - A code is valid only if exactly one bit is 0.
  - The counter restarts whenever the registered anode code changes.
- Sampling: when a valid code has been stable for exactly SETTLE cycles, segments are inverted, decoded and sampled once per slot. A glitch shorter than SETTLE is never sampled.
- Decode table (active-high a..g, hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Any other pattern is invalid.
- FSM states:
  - SYNC: wait for a sample with slot 0; go to CAP.
  - CAP: expect slots strictly in order 0→1→2→3. An out-of-order slot, an invalid pattern, or an illegal anode code held ≥SETTLE cycles pulses err_pattern (out-of-order excluded) and returns to SYNC. A sample of slot 3 goes to CHECK.
  - CHECK (1 cycle): range-check, compute mins=tens*10+ones and hrs=tens*10+ones, then return to CAP expecting slot 0.
- Confirmation:
  - Out of range: pulse err_range, clear the candidate, outputs unchanged.
  - In range and equal to the candidate from the previous frame: load hrs/mins, set time_valid, pulse time_stb. This happens even if the time is unchanged, so time_stb fires once per confirmed frame.
  - In range but differing from the candidate: store it as the new candidate, no output change.
- Latency: time_stb, err_range and the hrs/mins update are registered outputs, asserted exactly 2 clk after the edge that samples slot 3. err_pattern is asserted 1 clk after the offending sample.
- Stall:
  - stall=1 when the counter reaches TIMEOUT with no valid code change; the counter saturates.
  - On stall: clear time_valid, clear the candidate, FSM to SYNC.
  - stall clears on the first valid anode change.
- Simultaneous events: a stall on the same cycle as CHECK wins; no time_stb is issued.
- Width: all arithmetic in 7 bits, truncated into output widths after the range check.

Decomposition:
- Package seg_scan_pkg:
  - segment pattern constants SEG_0..SEG_9
  - anode slot codes AN_MIN_LO, AN_MIN_HI, AN_HR_LO, AN_HR_HI
  - FSM state enum {SYNC, CAP, CHECK}
- One sub-module, seg7_decode: combinational 7-bit active-high pattern → 4-bit digit plus valid flag.

Test Plan:
- Two frames of 12:34, SETTLE+100 cycles per slot → after the 2nd frame: hrs=12, mins=34, time_valid=1, exactly one time_stb, 2 clk after the slot-3 sample.
- Frame 12:34 then 12:35, then 12:35 again → no update after the 2nd frame; hrs=12, mins=35 and time_stb after the 3rd.
- Slot 1 carries pattern 49 → err_pattern pulse, FSM back to SYNC, outputs hold previous values, next two good frames confirm.
- Two frames of 25:07 → err_range pulse per frame, time_valid unchanged, no time_stb.
- Confirmed 09:59, then anodes held at 1110 for TIMEOUT+1 cycles → stall=1, time_valid=0; resumed scanning of 10:00 twice → stall=0, hrs=10, mins=0.
- An anode glitch of SETTLE-1 cycles to 0111 inside slot 1 → not sampled, no error. Reset asserted mid-frame → all outputs 0 immediately; two full frames are needed before time_stb.
